// File: rtl/accumulate_ctrl_if.sv
// Handshake bundle between the accumulate controller and its surroundings:
// the run/clear buttons, the switch operand, the external adder and the status outputs.
interface accumulate_ctrl_if;
   logic        Run_i;
   logic        Clear_i;
   logic [15:0] SW_i;
   logic [15:0] A_o;
   logic [15:0] B_o;
   logic        Cin_o;
   logic [15:0] S_i;
   logic        Cout_i;
   logic [15:0] Acc_o;
   logic        Carry_o;
   logic        Busy_o;
   logic        Done_o;

   modport slave (
      input  Run_i, Clear_i, SW_i, S_i, Cout_i,
      output A_o, B_o, Cin_o, Acc_o, Carry_o, Busy_o, Done_o
   );

   modport master (
      output Run_i, Clear_i, SW_i, S_i, Cout_i,
      input  A_o, B_o, Cin_o, Acc_o, Carry_o, Busy_o, Done_o
   );
endinterface

// File: rtl/accumulate_ctrl.sv
// Button-driven accumulator controller: each Run press latches the switches into the
// external adder, waits SETTLE_CYCLES for the sum to settle, then captures it.
module accumulate_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   accumulate_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LAUNCH  = 2'd1,
      SETTLE  = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

   logic [2:0]  r_sync;
   logic        w_start;
   state_t      r_state;
   logic [7:0]  r_cnt;
   logic [15:0] r_a;
   logic [15:0] r_acc;
   logic        r_carry;
   logic        r_busy;
   logic        r_done;

   // Two synchronizer stages plus one delay stage for rising-edge detection.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_sync <= 3'b000;
      end else begin
         r_sync <= {r_sync[1:0], bus.Run_i};
      end
   end

   assign w_start = r_sync[1] & ~r_sync[2];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= IDLE;
         r_cnt   <= 8'd0;
         r_a     <= 16'd0;
         r_acc   <= 16'd0;
         r_carry <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (bus.Clear_i) begin
         // Clear beats both a pending start and the SETTLE->CAPTURE capture.
         r_state <= IDLE;
         r_cnt   <= 8'd0;
         r_acc   <= 16'd0;
         r_carry <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_a     <= bus.SW_i;
                  r_busy  <= 1'b1;
                  r_state <= LAUNCH;
               end
            end
            LAUNCH: begin
               r_cnt   <= SETTLE_LOAD;
               r_state <= SETTLE;
            end
            SETTLE: begin
               if (r_cnt == 8'd0) begin
                  r_acc   <= bus.S_i;
                  r_carry <= r_carry | bus.Cout_i;
                  r_done  <= 1'b1;
                  r_state <= CAPTURE;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            CAPTURE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.A_o     = r_a;
   assign bus.B_o     = r_acc;
   assign bus.Cin_o   = 1'b0;
   assign bus.Acc_o   = r_acc;
   assign bus.Carry_o = r_carry;
   assign bus.Busy_o  = r_busy;
   assign bus.Done_o  = r_done;

endmodule

// File: tb/tb_accumulate_ctrl.sv
// Directed bench for accumulate_ctrl with a two-cycle registered adder model on S_i/Cout_i.
module tb_accumulate_ctrl;

   localparam int SETTLE = 4;
   localparam int LAT    = 4 + SETTLE;

   logic Clk;
   logic Reset;
   int   vectors;
   int   miscompares;
   logic [16:0] sum_d1;
   logic [16:0] sum_d2;

   accumulate_ctrl_if bus ();

   accumulate_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Adder settles two cycles after its operands change, well inside the settle window.
   always @(posedge Clk) begin
      sum_d1 <= {1'b0, bus.A_o} + {1'b0, bus.B_o};
      sum_d2 <= sum_d1;
   end
   assign bus.S_i    = sum_d2[15:0];
   assign bus.Cout_i = sum_d2[16];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Called at a negedge. Cycle c=1 is the first posedge that samples Run_i=1.
   task automatic press(input logic [15:0] sw, input int hold,
                        input logic [15:0] sw2, input int chg,
                        output int n_done, output int lat);
      bus.SW_i  = sw;
      bus.Run_i = 1'b1;
      n_done    = 0;
      lat       = -1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge Clk);
         @(negedge Clk);
         if (c == hold) bus.Run_i = 1'b0;
         if (c == chg)  bus.SW_i  = sw2;
         if (bus.Done_o === 1'b1) begin
            n_done++;
            if (lat < 0) lat = c;
         end
      end
      $display("press sw=%h hold=%0d -> acc=%h carry=%b done_pulses=%0d latency=%0d",
               sw, hold, bus.Acc_o, bus.Carry_o, n_done, lat);
   endtask

   task automatic clear_pulse();
      bus.Clear_i = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      bus.Clear_i = 1'b0;
   endtask

   initial begin
      int nd;
      int lt;
      vectors     = 0;
      miscompares = 0;
      Reset       = 1'b1;
      bus.Run_i   = 1'b0;
      bus.Clear_i = 1'b0;
      bus.SW_i    = 16'h0000;

      // Reset state
      repeat (3) @(negedge Clk);
      check("rst_A",     32'(bus.A_o),     32'h0);
      check("rst_Acc",   32'(bus.Acc_o),   32'h0);
      check("rst_B",     32'(bus.B_o),     32'h0);
      check("rst_Carry", 32'(bus.Carry_o), 32'h0);
      check("rst_Busy",  32'(bus.Busy_o),  32'h0);
      check("rst_Done",  32'(bus.Done_o),  32'h0);
      check("rst_Cin",   32'(bus.Cin_o),   32'h0);
      Reset = 1'b0;
      @(negedge Clk);

      // Two presses of +1
      press(16'h0001, 3, 16'h0001, 0, nd, lt);
      check("p1_done",  32'(nd), 32'd1);
      check("p1_lat",   32'(lt), 32'(LAT));
      check("p1_acc",   32'(bus.Acc_o), 32'h0001);
      check("p1_busy",  32'(bus.Busy_o), 32'h0);
      press(16'h0001, 3, 16'h0001, 0, nd, lt);
      check("p2_done",  32'(nd), 32'd1);
      check("p2_acc",   32'(bus.Acc_o), 32'h0002);
      check("p2_B",     32'(bus.B_o), 32'h0002);
      check("p2_carry", 32'(bus.Carry_o), 32'h0);

      // Clear keeps A_o
      clear_pulse();
      check("clr_acc", 32'(bus.Acc_o), 32'h0);
      check("clr_A",   32'(bus.A_o),   32'h0001);

      // Wrap-around and sticky carry
      press(16'hFFFF, 3, 16'hFFFF, 0, nd, lt);
      check("w0_acc",   32'(bus.Acc_o),   32'hFFFF);
      check("w0_carry", 32'(bus.Carry_o), 32'h0);
      press(16'h0001, 3, 16'h0001, 0, nd, lt);
      check("w1_acc",   32'(bus.Acc_o),   32'h0000);
      check("w1_carry", 32'(bus.Carry_o), 32'h1);
      press(16'h0001, 3, 16'h0001, 0, nd, lt);
      check("w2_acc",   32'(bus.Acc_o),   32'h0001);
      check("w2_carry", 32'(bus.Carry_o), 32'h1);

      // Run held for 50 cycles
      press(16'h0003, 50, 16'h0003, 0, nd, lt);
      check("hold_done", 32'(nd), 32'd1);
      check("hold_lat",  32'(lt), 32'(LAT));
      check("hold_acc",  32'(bus.Acc_o), 32'h0004);

      // Switch change during SETTLE is ignored
      press(16'h0005, 3, 16'h0100, 6, nd, lt);
      check("sw_acc",  32'(bus.Acc_o), 32'h0009);
      check("sw_A",    32'(bus.A_o),   32'h0005);
      check("sw_done", 32'(nd), 32'd1);

      // Clear during SETTLE
      bus.SW_i  = 16'h0007;
      bus.Run_i = 1'b1;
      repeat (6) @(negedge Clk);
      check("cs_busy_before", 32'(bus.Busy_o), 32'h1);
      bus.Run_i = 1'b0;
      clear_pulse();
      check("cs_acc",   32'(bus.Acc_o),   32'h0);
      check("cs_carry", 32'(bus.Carry_o), 32'h0);
      check("cs_busy",  32'(bus.Busy_o),  32'h0);
      nd = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge Clk);
         if (bus.Done_o === 1'b1) nd++;
      end
      check("cs_nodone", 32'(nd), 32'd0);
      check("cs_acc_after", 32'(bus.Acc_o), 32'h0);

      // Reset between edges in SETTLE
      press(16'h0002, 3, 16'h0002, 0, nd, lt);
      check("pre_rst_acc", 32'(bus.Acc_o), 32'h0002);
      bus.SW_i  = 16'h0009;
      bus.Run_i = 1'b1;
      repeat (6) @(negedge Clk);
      #2 Reset = 1'b1;
      #1;
      check("ar_acc",  32'(bus.Acc_o),   32'h0);
      check("ar_A",    32'(bus.A_o),     32'h0);
      check("ar_busy", 32'(bus.Busy_o),  32'h0);
      check("ar_done", 32'(bus.Done_o),  32'h0);
      check("ar_carry",32'(bus.Carry_o), 32'h0);

      // Run held through reset release starts once, after synchronization
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      press(16'h0005, 3, 16'h0005, 0, nd, lt);
      check("rr_done", 32'(nd), 32'd1);
      check("rr_lat",  32'(lt), 32'(LAT));
      check("rr_acc",  32'(bus.Acc_o), 32'h0005);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
